// File: rtl/ixc_assign_arb_72.sv
// Four-requester round-robin arbiter feeding a one-entry 72-bit channel register.
// Optional macro IXC_ASSIGN_ARB_PARITY_EN enables byte-parity checking of accepted payloads.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The data must be stable while valid is 1 and ready is 0. Ready may depend on valid.
module ixc_assign_arb_72 #(
  parameter int NREQ = 4,
  parameter int W    = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [1:0]        out_src,
  input  logic              out_ready,
  output logic [15:0]       xfer_cnt,
  output logic              par_err,
  output logic [1:0]        par_err_src
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [1:0]   rr_ptr;
  logic [1:0]   gnt_idx;
  logic [1:0]   scan_idx;
  logic         gnt_any;
  logic         can_load;
  logic         grant;
  logic [W-1:0] sel_data;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = rr_ptr;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = rr_ptr + 2'(i);
      if (req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign can_load  = (state_q == EMPTY) || out_ready;
  assign grant     = rst_n && can_load && gnt_any;
  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign sel_data  = req_data[int'(gnt_idx)*W +: W];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (grant)                            state_d = FULL;
    else if (state_q == FULL && out_ready) state_d = EMPTY;
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
      xfer_cnt <= '0;
    end else begin
      if (grant) begin
        out_data <= sel_data;
        out_src  <= gnt_idx;
        rr_ptr   <= gnt_idx + 2'd1;
      end
      if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

`ifdef IXC_ASSIGN_ARB_PARITY_EN
  logic par_bad;

  always_comb begin
    par_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (sel_data[64+k] != ^sel_data[8*k +: 8]) par_bad = 1'b1;
    end
  end

  // Only the first error records its source; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err     <= 1'b0;
      par_err_src <= '0;
    end else if (grant && par_bad && !par_err) begin
      par_err     <= 1'b1;
      par_err_src <= gnt_idx;
    end
  end
`else
  assign par_err     = 1'b0;
  assign par_err_src = 2'd0;
`endif

endmodule

// File: tb/tb_ixc_assign_arb_72.sv
// Directed bench for ixc_assign_arb_72; define IXC_ASSIGN_ARB_PARITY_EN to exercise the parity build.
module tb_ixc_assign_arb_72;

  localparam int NREQ = 4;
  localparam int W    = 72;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [1:0]        out_src;
  logic              out_ready = 1'b0;
  logic [15:0]       xfer_cnt;
  logic              par_err;
  logic [1:0]        par_err_src;

  int tests = 0;
  int fails = 0;

  logic [W-1:0]    pay [NREQ];
  logic [NREQ-1:0] pend_q = '0;
  logic [NREQ*W-1:0] pend_data_q = '0;

  ixc_assign_arb_72 #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .xfer_cnt(xfer_cnt),
    .par_err(par_err), .par_err_src(par_err_src)
  );

  always #5 clk = ~clk;

  // Requester obligation: a pending request keeps valid and data stable until accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend_q[i] && (!req_valid[i] || req_data[i*W +: W] !== pend_data_q[i*W +: W])) begin
          fails++;
          $display("FAIL req_hold[%0d]: valid=%b data=%h, required valid=1 data=%h",
                   i, req_valid[i], req_data[i*W +: W], pend_data_q[i*W +: W]);
        end
      end
      pend_q <= req_valid & ~req_ready;
    end else begin
      pend_q <= '0;
    end
    pend_data_q <= req_data;
  end

  function automatic logic [W-1:0] mk(input logic [63:0] d);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) p[k] = ^d[8*k +: 8];
    return {p, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pay();
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = pay[i];
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b, required 0000", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_data, out_src, xfer_cnt, par_err, par_err_src} !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h src=%0d cnt=%0d perr=%b psrc=%0d, required all 0",
               out_valid, out_data, out_src, xfer_cnt, par_err, par_err_src);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    pay[2] = mk(64'h0123_4567_89ab_cdef);
    set_pay();
    req_valid = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL single_ready: got %b, required 0100", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== pay[2]) begin
      fails++;
      $display("FAIL single_out: valid=%b src=%0d data=%h, required 1/2/%h",
               out_valid, out_src, out_data, pay[2]);
    end
    step();
    @(negedge clk);
    tests++;
    if (xfer_cnt !== 16'd1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL single_cnt: cnt=%0d valid=%b, required 1/0", xfer_cnt, out_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) pay[i] = mk(64'h1111_0000_0000_0000 * (i + 1) + 64'(i));
    set_pay();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== (4'b0001 << (c % 4))) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got %b, required %b", c, req_ready, 4'b0001 << (c % 4));
      end
      if (c > 0) begin
        tests++;
        if (out_valid !== 1'b1 || out_src !== 2'((c - 1) % 4) || out_data !== pay[(c - 1) % 4]
            || xfer_cnt !== 16'(c - 1)) begin
          fails++;
          $display("FAIL rr_out[%0d]: valid=%b src=%0d data=%h cnt=%0d, required 1/%0d/%h/%0d",
                   c, out_valid, out_src, out_data, xfer_cnt, (c - 1) % 4, pay[(c - 1) % 4], c - 1);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    pay[0] = mk(64'hdead_beef_0000_0001);
    pay[1] = mk(64'hcafe_f00d_0000_0002);
    set_pay();
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL stall_first: got %b, required 0001", req_ready);
    end
    step();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== pay[0] || out_src !== 2'd0 || req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h src=%0d ready=%b, required 1/%h/0/0000",
                 c, out_valid, out_data, out_src, req_ready, pay[0]);
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++; $display("FAIL stall_release: got %b, required 0010", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== pay[1] || xfer_cnt !== 16'd1) begin
      fails++;
      $display("FAIL stall_next: valid=%b src=%0d data=%h cnt=%0d, required 1/1/%h/1",
               out_valid, out_src, out_data, xfer_cnt, pay[1]);
    end
    step();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || xfer_cnt !== 16'd2) begin
      fails++; $display("FAIL stall_drain: valid=%b cnt=%0d, required 0/2", out_valid, xfer_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pay[0] = mk(64'h5a5a_5a5a_5a5a_5a5a);
    set_pay();
    req_valid = 4'b0001;
    out_ready = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    tests++;
    if (xfer_cnt !== 16'hffff) begin
      fails++; $display("FAIL wrap_max: got %h, required ffff", xfer_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (xfer_cnt !== 16'h0000) begin
      fails++; $display("FAIL wrap_zero: got %h, required 0000", xfer_cnt);
    end
  endtask

  task automatic test_parity();
    logic [W-1:0] bad3;
    logic [W-1:0] bad1;
    logic         exp_err;
    logic [1:0]   exp_src;
`ifdef IXC_ASSIGN_ARB_PARITY_EN
    exp_err = 1'b1;
    exp_src = 2'd3;
`else
    exp_err = 1'b0;
    exp_src = 2'd0;
`endif
    bad3 = {8'h00, 64'h0000_0000_0000_0001};
    bad1 = {8'hff, 64'h0000_0000_0000_0000};
    do_reset();
    pay[0] = mk(64'h0f0f_0f0f_1234_5678);
    pay[3] = bad3;
    pay[1] = bad1;
    pay[2] = mk(64'h8000_0000_0000_0001);
    set_pay();
    out_ready = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    tests++;
    if (par_err !== 1'b0) begin
      fails++; $display("FAIL par_good: got %b, required 0", par_err);
    end
    step();
    req_valid = 4'b0010;
    @(negedge clk);
    tests++;
    if (par_err !== exp_err || par_err_src !== exp_src || out_data !== bad3 || out_src !== 2'd3) begin
      fails++;
      $display("FAIL par_first: err=%b src=%0d data=%h osrc=%0d, required %b/%0d/%h/3",
               par_err, par_err_src, out_data, out_src, exp_err, exp_src, bad3);
    end
    step();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    tests++;
    if (par_err !== exp_err || par_err_src !== exp_src) begin
      fails++;
      $display("FAIL par_sticky: err=%b src=%0d, required %b/%0d", par_err, par_err_src, exp_err, exp_src);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pay[2] = mk(64'h7777_6666_5555_4444);
    pay[0] = mk(64'h0000_0000_0000_00aa);
    set_pay();
    req_valid = 4'b0100;
    out_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || xfer_cnt !== 16'd0 || req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL reset_mid: valid=%b cnt=%0d ready=%b, required 0/0/0001",
               out_valid, xfer_cnt, req_ready);
    end
    step();
    @(negedge clk);
    tests++;
    if (out_src !== 2'd0 || out_data !== pay[0]) begin
      fails++;
      $display("FAIL reset_mid_out: src=%0d data=%h, required 0/%h", out_src, out_data, pay[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_parity();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ixc_assign_arb_72.md
IXC_ASSIGN_ARB_72 -- requirements
Module: ixc_assign_arb_72

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing the 72-bit assign channel (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter W, default 72, giving the channel width in bits: bits [63:0] are data and bits [71:64] are byte parity.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, NREQ, the per-requester transfer request.
REQ-006 The block SHALL have port req_data, input, NREQ*W, the per-requester payload; requester i occupies bits [i*W +: W].
REQ-007 The block SHALL have port req_ready, output, NREQ, the one-hot acceptance: requester i is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-008 The block SHALL have port out_valid, output, 1, indicating the channel register holds a transfer.
REQ-009 The block SHALL have port out_data, output, W, the channel register payload.
REQ-010 The block SHALL have port out_src, output, 2, the index of the requester that owns out_data.
REQ-011 The block SHALL have port out_ready, input, 1, the sink acceptance.
REQ-012 The block SHALL have port xfer_cnt, output, 16, the count of completed sink transfers.
REQ-013 The block SHALL have port par_err, output, 1, the sticky parity-error flag.
REQ-014 The block SHALL have port par_err_src, output, 2, the requester that caused the first parity error.

Function
REQ-015 The block SHALL hold a one-entry channel register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 The block SHALL be able to load the register when it is EMPTY, or when it is FULL and out_ready=1 in the same cycle (back-to-back, no bubble).
REQ-017 When the register can load and any req_valid is set, the block SHALL assert exactly one req_ready bit, chosen round-robin starting from the pointer rr_ptr; otherwise req_ready SHALL be 0.
REQ-018 req_ready SHALL be combinational from req_valid, rr_ptr, out_valid and out_ready.
REQ-019 An accepted payload SHALL appear on out_data and out_src, with out_valid=1, on the next cycle (latency 1).
REQ-020 After each grant to requester g, rr_ptr SHALL become (g+1) mod 4; rr_ptr SHALL be unchanged when there is no grant.
REQ-021 While the register is FULL and out_ready=0, out_data and out_src SHALL hold stable and req_ready SHALL be 0.
REQ-022 When the register is FULL, out_ready=1 and there is no new grant, the register SHALL go EMPTY on the next cycle.
REQ-023 xfer_cnt SHALL increment by 1 for each cycle with out_valid and out_ready both 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 A requester SHALL keep req_valid and req_data stable until accepted; this is a requester obligation and is asserted by the bench, not by the block.

Reset
REQ-025 When rst_n=0 at a rising clk edge, the block SHALL set out_valid=0, out_data=0, out_src=0, rr_ptr=0, xfer_cnt=0, par_err=0 and par_err_src=0.
REQ-026 req_ready SHALL be 0 while rst_n=0.
REQ-027 Reset mid-transfer SHALL drop any held payload without a sink handshake, and xfer_cnt SHALL not count it.

Configuration
REQ-028 With macro IXC_ASSIGN_ARB_PARITY_EN defined, the block SHALL check each accepted payload: bit 64+k must equal the even parity (XOR) of data byte k, for k=0..7.
REQ-029 With IXC_ASSIGN_ARB_PARITY_EN defined, the first mismatch SHALL set par_err=1 and capture par_err_src on the cycle after acceptance; par_err SHALL hold until reset, and later errors SHALL not change par_err_src.
REQ-030 With IXC_ASSIGN_ARB_PARITY_EN defined, the payload SHALL still be forwarded unchanged.
REQ-031 Without IXC_ASSIGN_ARB_PARITY_EN, par_err and par_err_src SHALL be tied to 0 and no check logic SHALL be present; the ports SHALL exist in both builds.

Verification
REQ-032 The bench SHALL cover: rst_n=0, then a single request req_valid=4'b0100 with out_ready=1 -> req_ready=4'b0100 in cycle 0; out_valid=1, out_src=2 in cycle 1; xfer_cnt=1 in cycle 2.
REQ-033 The bench SHALL cover: all four requesters valid continuously with out_ready=1 -> grants follow the order 0,1,2,3,0 with one transfer per cycle and no idle cycle.
REQ-034 The bench SHALL cover: out_ready=0 for 5 cycles while the register is FULL -> out_data stable, req_ready=0; on out_ready=1 the next grant is accepted the same cycle.
REQ-035 The bench SHALL cover: 65536 transfers -> xfer_cnt wraps to 0x0000.
REQ-036 The bench SHALL cover, with IXC_ASSIGN_ARB_PARITY_EN defined: requester 3 sends data 0x01 with parity 0x00 -> par_err=1 and par_err_src=3 the next cycle, and par_err stays 1 through later good traffic; without the macro, par_err stays 0.
REQ-037 The bench SHALL cover: rst_n=0 asserted while FULL with out_ready=0 -> next cycle out_valid=0 and rr_ptr=0, so the next grant goes to requester 0 first.
